// File: rtl/loop_sequencer_if.sv
// Command, address-stream, status and loop-generator signal bundle for loop_sequencer.
interface loop_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_threshold;
  logic [ADDR_W-1:0] cmd_stride;
  logic [CNT_W-1:0]  cmd_outer_count;
  logic [ADDR_W-1:0] cmd_outer_stride;
  logic              abort;

  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr_data;

  logic              done;
  logic              error;

  logic [4:0]        gen_reg_index;
  logic [ADDR_W-1:0] gen_threshold;
  logic [ADDR_W-1:0] gen_increment;
  logic              gen_init_we;
  logic              gen_increase;
  logic [ADDR_W-1:0] gen_address;
  logic              gen_loop;

  // Controller side
  modport slave (
    input  cmd_valid, cmd_base, cmd_threshold, cmd_stride, cmd_outer_count,
           cmd_outer_stride, abort, addr_ready, gen_address, gen_loop,
    output cmd_ready, addr_valid, addr_data, done, error, gen_reg_index,
           gen_threshold, gen_increment, gen_init_we, gen_increase
  );

  // Command source, address consumer and generator side
  modport master (
    output cmd_valid, cmd_base, cmd_threshold, cmd_stride, cmd_outer_count,
           cmd_outer_stride, abort, addr_ready, gen_address, gen_loop,
    input  cmd_ready, addr_valid, addr_data, done, error, gen_reg_index,
           gen_threshold, gen_increment, gen_init_we, gen_increase
  );
endinterface

// File: rtl/loop_sequencer.sv
// Sequences an external offset/increment/threshold generator through a two-level
// nested loop and streams base-relocated addresses to a consumer.
module loop_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter logic [4:0]  REG_INDEX = 5'd0
) (
  input  logic            clock,
  input  logic            reset,
  loop_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_STREAM  = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [ADDR_W-1:0] threshold_q;
  logic [ADDR_W-1:0] threshold_nx;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] stride_nx;
  logic [ADDR_W-1:0] outer_stride_q;
  logic [ADDR_W-1:0] outer_stride_nx;
  logic [ADDR_W-1:0] cur_base_q;
  logic [ADDR_W-1:0] cur_base_nx;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  remaining_nx;
  logic              error_q;
  logic              error_nx;

  logic              cmd_ready_c;
  logic              addr_valid_c;
  logic              gen_increase_c;
  logic              gen_init_we_c;
  logic              last_beat_c;
  logic [ADDR_W:0]   next_offset_c;

  // Init strobe kept out of the main block: the generator's loop flag depends on it
  assign gen_init_we_c = (state == S_INIT) && !bus.abort;

  // The beat being accepted is the last of this outer iteration when the next
  // offset reaches the threshold; lets the FSM skip the empty loop-flag cycle.
  assign next_offset_c = {1'b0, bus.gen_address} + {1'b0, stride_q};
  assign last_beat_c   = next_offset_c >= {1'b0, threshold_q};

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      threshold_q    <= '0;
      stride_q       <= '0;
      outer_stride_q <= '0;
      cur_base_q     <= '0;
      remaining_q    <= '0;
      error_q        <= 1'b0;
    end else begin
      state          <= state_nx;
      threshold_q    <= threshold_nx;
      stride_q       <= stride_nx;
      outer_stride_q <= outer_stride_nx;
      cur_base_q     <= cur_base_nx;
      remaining_q    <= remaining_nx;
      error_q        <= error_nx;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_nx        = state;
    threshold_nx    = threshold_q;
    stride_nx       = stride_q;
    outer_stride_nx = outer_stride_q;
    cur_base_nx     = cur_base_q;
    remaining_nx    = remaining_q;
    error_nx        = error_q;
    cmd_ready_c     = 1'b0;
    addr_valid_c    = 1'b0;
    gen_increase_c  = 1'b0;

    unique case (state)
      S_IDLE: begin
        // Abort in idle is otherwise ignored but blocks a simultaneous command
        cmd_ready_c = reset && !bus.abort;
        if (bus.cmd_valid && cmd_ready_c) begin
          threshold_nx    = bus.cmd_threshold;
          stride_nx       = bus.cmd_stride;
          outer_stride_nx = bus.cmd_outer_stride;
          cur_base_nx     = bus.cmd_base;
          remaining_nx    = bus.cmd_outer_count;
          if ((bus.cmd_threshold == '0) || (bus.cmd_outer_count == '0)) begin
            state_nx = S_DONE;
            error_nx = 1'b0;
          end else if (bus.cmd_stride == '0) begin
            state_nx = S_DONE;
            error_nx = 1'b1;
          end else begin
            state_nx = S_INIT;
          end
        end
      end

      S_INIT: begin
        if (bus.abort) begin
          state_nx = S_DONE;
          error_nx = 1'b1;
        end else begin
          state_nx = S_STREAM;
        end
      end

      S_STREAM: begin
        if (bus.abort) begin
          state_nx = S_DONE;
          error_nx = 1'b1;
        end else if (!bus.gen_loop) begin
          state_nx = S_ADVANCE;
        end else begin
          addr_valid_c = 1'b1;
          if (bus.addr_ready) begin
            gen_increase_c = 1'b1;
            if (last_beat_c) begin
              state_nx = S_ADVANCE;
            end
          end
        end
      end

      S_ADVANCE: begin
        if (bus.abort) begin
          state_nx = S_DONE;
          error_nx = 1'b1;
        end else if (remaining_q == CNT_W'(1)) begin
          state_nx = S_DONE;
          error_nx = 1'b0;
        end else begin
          remaining_nx = remaining_q - CNT_W'(1);
          cur_base_nx  = cur_base_q + outer_stride_q;
          state_nx     = S_INIT;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.addr_valid    = addr_valid_c;
  assign bus.addr_data     = (state == S_STREAM) ? (cur_base_q + bus.gen_address) : '0;
  assign bus.done          = (state == S_DONE);
  assign bus.error         = (state == S_DONE) && error_q;
  assign bus.gen_reg_index = REG_INDEX;
  assign bus.gen_threshold = threshold_q;
  assign bus.gen_increment = stride_q;
  assign bus.gen_init_we   = gen_init_we_c;
  assign bus.gen_increase  = gen_increase_c;

endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer with a behavioural loop generator model.
module tb_loop_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   init_cnt = 0;

  // addr_ready pattern: mode 0 = always ready, mode 1 = 1,0,0 repeating from rbase
  int   ready_mode  = 0;
  int   ready_base  = 0;

  typedef struct {
    bit          is_done;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  loop_sequencer_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  loop_sequencer #(.ADDR_W(32), .CNT_W(16), .REG_INDEX(5'd0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural generator: offset reloads on init, steps on increase
  logic [31:0] g_off;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                g_off <= '0;
    else if (bus.gen_init_we)  g_off <= '0;
    else if (bus.gen_increase) g_off <= g_off + bus.gen_increment;
  end
  assign bus.gen_address = g_off;
  assign bus.gen_loop    = bus.gen_init_we | (g_off < bus.gen_threshold);

  always @(posedge clock) begin
    #1;
    if (ready_mode == 0) bus.addr_ready = 1'b1;
    else                 bus.addr_ready = (((cyc - ready_base) % 3) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_addr(input logic [31:0] data, input int c);
    exp_t e;
    e.is_done = 1'b0; e.data = data; e.err = 1'b0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit err, input int c);
    exp_t e;
    e.is_done = 1'b1; e.data = '0; e.err = err; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input bit is_done, input logic [31:0] data, input bit err);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s actual data=%h err=%0d cycle=%0d required=nothing",
               is_done ? "done" : "addr", data, err, cyc);
    end else begin
      e = exp_q.pop_front();
      if ((e.is_done != is_done) || (e.cyc != cyc) ||
          (!is_done && (e.data != data)) || (is_done && (e.err != err))) begin
        bad++;
        $display("FAIL scoreboard actual done=%0d data=%h err=%0d cycle=%0d required done=%0d data=%h err=%0d cycle=%0d",
                 is_done, data, err, cyc, e.is_done, e.data, e.err, e.cyc);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every accepted address and every done pulse
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clock) begin
    if (reset) begin
      if (bus.addr_valid && bus.addr_ready) pop_check(1'b0, bus.addr_data, 1'b0);
      if (bus.done) pop_check(1'b1, 32'h0, bus.error);
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(bus.addr_valid), 32'd1);
        chk("stall_hold_data", bus.addr_data, prev_data);
      end
      chk("gen_increase_on_accept", 32'(bus.gen_increase),
          32'(bus.addr_valid && bus.addr_ready));
      prev_stall = bus.addr_valid && !bus.addr_ready;
      prev_data  = bus.addr_data;
      if (bus.gen_init_we) init_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [31:0] base, input logic [31:0] th, input logic [31:0] st,
                      input logic [15:0] oc, input logic [31:0] os, output int t);
    t = -1;
    @(posedge clock); #1;
    bus.cmd_valid        = 1'b1;
    bus.cmd_base         = base;
    bus.cmd_threshold    = th;
    bus.cmd_stride       = st;
    bus.cmd_outer_count  = oc;
    bus.cmd_outer_stride = os;
    for (int i = 0; i < 50 && t < 0; i++) begin
      @(negedge clock);
      if (bus.cmd_ready) t = cyc;
    end
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    if (t < 0) begin
      total++; bad++;
      $display("FAIL cmd_accept actual=not_accepted required=accepted");
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clock);
    repeat (4) @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual_pending=%0d required_pending=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int i0;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_threshold = '0; bus.cmd_stride = '0;
    bus.cmd_outer_count = '0; bus.cmd_outer_stride = '0; bus.abort = 1'b0;
    bus.addr_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_init_we", 32'(bus.gen_init_we), 32'd0);
    chk("rst_gen_threshold", bus.gen_threshold, 32'd0);
    chk("rst_gen_increment", bus.gen_increment, 32'd0);
    chk("rst_addr_data", bus.addr_data, 32'd0);
    chk("rst_reg_index", 32'(bus.gen_reg_index), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single outer iteration, ready held high
    i0 = init_cnt;
    send(32'h100, 32'd12, 32'd4, 16'd1, 32'h0, t);
    push_addr(32'h100, t + 2); push_addr(32'h104, t + 3); push_addr(32'h108, t + 4);
    push_done(1'b0, t + 6);
    drain();
    chk("init_pulses_1", 32'(init_cnt - i0), 32'd1);

    // Three outer iterations with two-cycle bubbles
    i0 = init_cnt;
    send(32'h1000, 32'd8, 32'd4, 16'd3, 32'h40, t);
    push_addr(32'h1000, t + 2);  push_addr(32'h1004, t + 3);
    push_addr(32'h1040, t + 6);  push_addr(32'h1044, t + 7);
    push_addr(32'h1080, t + 10); push_addr(32'h1084, t + 11);
    push_done(1'b0, t + 13);
    drain();
    chk("init_pulses_3", 32'(init_cnt - i0), 32'd3);

    // Consumer stalls in a 1,0,0 pattern
    send(32'h100, 32'd12, 32'd4, 16'd1, 32'h0, t);
    ready_base = t + 2;
    ready_mode = 1;
    push_addr(32'h100, t + 2); push_addr(32'h104, t + 5); push_addr(32'h108, t + 8);
    push_done(1'b0, t + 10);
    drain();
    ready_mode = 0;

    // Empty command and zero-stride rejection
    i0 = init_cnt;
    send(32'h0, 32'd0, 32'd4, 16'd1, 32'h0, t);
    push_done(1'b0, t + 1);
    drain();
    send(32'h0, 32'd5, 32'd0, 16'd1, 32'h0, t);
    push_done(1'b1, t + 1);
    drain();
    chk("init_pulses_rejected", 32'(init_cnt - i0), 32'd0);

    // Base relocation wraps modulo 2^32
    send(32'hFFFF_FFF8, 32'd16, 32'd8, 16'd1, 32'h0, t);
    push_addr(32'hFFFF_FFF8, t + 2); push_addr(32'h0000_0000, t + 3);
    push_done(1'b0, t + 5);
    drain();

    // Abort while the second address is presented
    send(32'h200, 32'd12, 32'd4, 16'd1, 32'h0, t);
    push_addr(32'h200, t + 2);
    push_done(1'b1, t + 4);
    wait_cycle(t + 3);
    bus.abort = 1'b1;
    @(negedge clock);
    chk("abort_addr_valid", 32'(bus.addr_valid), 32'd0);
    chk("abort_gen_increase", 32'(bus.gen_increase), 32'd0);
    @(posedge clock); #1;
    bus.abort = 1'b0;
    wait_cycle(t + 5);
    @(negedge clock);
    chk("abort_ready_after", 32'(bus.cmd_ready), 32'd1);
    drain();

    // Asynchronous reset mid-stream: outputs drop at once, no done pulse
    send(32'h300, 32'd12, 32'd4, 16'd1, 32'h0, t);
    push_addr(32'h300, t + 2);
    wait_cycle(t + 3);
    #1 reset = 1'b0;
    #1;
    chk("mrst_addr_valid", 32'(bus.addr_valid), 32'd0);
    chk("mrst_addr_data", bus.addr_data, 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("mrst_gen_threshold", bus.gen_threshold, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (8) @(posedge clock);
    drain();
    @(negedge clock);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Command-driven controller that sequences one external loop address generator (offset/increment/threshold unit with init and increase strobes, combinational loop flag) through a two-level nested loop.
- Accepts a command over a valid/ready handshake and programs the generator once per outer iteration.
- Streams base-relocated addresses to a consumer over valid/ready, then pulses done (with error flag) at the end.
- Sits between the control FSM/decoder and the memory-address path.

Parameters:
- ADDR_W, 32, width of base, threshold, stride, outer stride and all addresses
- CNT_W, 16, width of outer iteration count
- REG_INDEX, 0, constant driven on gen_reg_index (5 bits)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_base  in  ADDR_W  base address of first outer iteration
- cmd_threshold  in  ADDR_W  inner-loop offset limit (exclusive)
- cmd_stride  in  ADDR_W  inner-loop offset increment
- cmd_outer_count  in  CNT_W  number of outer iterations
- cmd_outer_stride  in  ADDR_W  base increment per outer iteration
- abort  in  1  synchronous cancel of active command
- addr_valid  out  1  addr_data valid
- addr_ready  in  1  consumer accepts addr_data
- addr_data  out  ADDR_W  current base + generator offset
- done  out  1  one-cycle end-of-command pulse
- error  out  1  qualifies done: command rejected
- gen_reg_index  out  5  constant REG_INDEX
- gen_threshold  out  ADDR_W  to generator threshold input
- gen_increment  out  ADDR_W  to generator incrementer input
- gen_init_we  out  1  generator initialize strobe
- gen_increase  out  1  generator increase strobe
- gen_address  in  ADDR_W  generator offset output
- gen_loop  in  1  generator loop flag (offset < threshold; 1 during init cycle)

Behaviour:
- Reset (reset=0, async): state=IDLE; all latched registers 0. Outputs: cmd_ready=0 while reset is asserted, then 1 in IDLE; addr_valid=0, done=0, error=0, gen_init_we=0, gen_increase=0, gen_threshold=0, gen_increment=0, addr_data=0.
- States: IDLE, INIT, STREAM, ADVANCE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch threshold, stride, outer_count, outer_stride; cur_base <= cmd_base; remaining <= cmd_outer_count.
  - If threshold==0 or outer_count==0: go to DONE, error=0 (empty command, no addresses).
  - Else if stride==0: go to DONE, error=1 (infinite loop rejected).
  - Else go to INIT.
- INIT: gen_init_we=1 for exactly one cycle; go to STREAM.
- Generator drive: gen_threshold and gen_increment are driven from latched values and held stable from the INIT cycle until leaving STREAM. The generator compares against its live threshold input, so these must not change mid-loop.
- STREAM:
  - addr_valid = gen_loop; addr_data = cur_base + gen_address (mod 2^ADDR_W).
  - gen_increase = addr_valid & addr_ready, combinationally in the same cycle. The next offset appears the following cycle.
  - addr_data and addr_valid stay stable while addr_valid=1 and addr_ready=0.
  - When gen_loop=0: go to ADVANCE; no address issued that cycle.
- ADVANCE:
  - If remaining==1: go to DONE, error=0.
  - Else remaining <= remaining-1; cur_base <= cur_base + outer_stride (wraps); go to INIT.
- DONE: done=1 for one cycle (error valid with it); go to IDLE. cmd_ready=0.
- Latency:
  - Command accepted at cycle T; gen_init_we at T+1; first addr_valid at T+2.
  - With addr_ready held high: one address per cycle; 2 bubble cycles between outer iterations (ADVANCE, INIT); done 1 cycle after ADVANCE of the last iteration.
- Inner iteration count per outer iteration = ceil(threshold/stride). Offset overflow past 2^ADDR_W is not detected; commands must keep threshold + stride < 2^ADDR_W.
- abort:
  - In any state except IDLE: go to DONE next cycle with error=1; gen_increase and gen_init_we forced 0 in the abort cycle; addr_valid forced 0 that cycle.
  - Abort in IDLE is ignored; abort beats cmd_valid.
- cmd_valid in non-IDLE states is ignored (cmd_ready=0).
- Reset asserted mid-command: immediate return to IDLE, no done pulse.

Test Plan:
- base=0x100, threshold=12, stride=4, outer_count=1, addr_ready=1 -> addr_data 0x100, 0x104, 0x108 on consecutive cycles starting T+2; done=1, error=0 at T+6.
- base=0x1000, threshold=8, stride=4, outer_count=3, outer_stride=0x40 -> addresses 0x1000, 0x1004, 0x1040, 0x1044, 0x1080, 0x1084; exactly 2 invalid cycles between groups; single done pulse.
- Same as first case but addr_ready toggling 1,0,0,1,... -> addr_data held stable while stalled; gen_increase high only on accepted cycles; exactly 3 addresses delivered.
- threshold=0 -> done, error=0 at T+1, no addr_valid; stride=0, threshold=5 -> done, error=1 at T+1, gen_init_we never asserted.
- base=0xFFFFFFF8, threshold=16, stride=8 -> addresses 0xFFFFFFF8, 0x00000000 (wrap).
- abort during 2nd address of a 3-address stream -> addr_valid=0 in the abort cycle, done+error=1 the next cycle, cmd_ready=1 the cycle after; async reset pulse mid-stream -> all outputs 0 immediately, no done pulse.
